// File: rtl/mul_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mul_arb_pkg
// Brief    : Shared types and constants for the shared-multiplier arbiter.
// Revision : 1.0
// ============================================================================
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int unsigned c_CNT_W = 8;

  typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/mul_core.sv
`default_nettype none
// ============================================================================
// Module   : mul_core
// Brief    : Combinational N x N -> 2N unsigned multiplier.
// Revision : 1.0
// ============================================================================
module mul_core #(
  parameter int N = 4
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  // Widen before multiplying so the full 2N-bit product is kept.
  assign o_p = (2*N)'(i_a) * (2*N)'(i_b);

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_arbiter
// Brief    : Round-robin arbiter sharing one multiplier between two requesters.
// Revision : 1.0
// ============================================================================
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [N-1:0]       req0_a,
  input  logic [N-1:0]       req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [N-1:0]       req1_a,
  input  logic [N-1:0]       req1_b,
  output logic               req1_ready,
  output logic               res_valid,
  output logic [2*N-1:0]     res_product,
  output logic               res_id,
  input  logic               res_ready,
  output logic               busy,
  output logic [c_CNT_W-1:0] done_cnt0,
  output logic [c_CNT_W-1:0] done_cnt1
);

  state_t         r_state;
  state_t         w_next;
  req_id_t        r_last_grant;
  req_id_t        r_id;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           w_grant;
  req_id_t        w_grant_id;
  logic           w_done;
  logic [2*N-1:0] w_product;

  mul_core #(.N(N)) u_mul_core (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_product)
  );

  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_grant_id = r_last_grant;
    w_done     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      IDLE: begin
        // Gated by rst so no ready escapes while reset is held.
        if (!rst) begin
          if (req0_valid && req1_valid) begin
            w_grant    = 1'b1;
            w_grant_id = ~r_last_grant;
          end else if (req0_valid) begin
            w_grant    = 1'b1;
            w_grant_id = 1'b0;
          end else if (req1_valid) begin
            w_grant    = 1'b1;
            w_grant_id = 1'b1;
          end
        end
        req0_ready = w_grant && !w_grant_id;
        req1_ready = w_grant && w_grant_id;
        if (w_grant) w_next = CALC;
      end
      CALC: w_next = HOLD;
      HOLD: begin
        if (res_ready) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      res_product  <= '0;
      res_id       <= 1'b0;
      done_cnt0    <= '0;
      done_cnt1    <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_a          <= w_grant_id ? req1_a : req0_a;
        r_b          <= w_grant_id ? req1_b : req0_b;
        r_id         <= w_grant_id;
        r_last_grant <= w_grant_id;
      end
      if (r_state == CALC) begin
        res_product <= w_product;
        res_id      <= r_id;
      end
      if (w_done) begin
        if (res_id) done_cnt1 <= done_cnt1 + c_CNT_W'(1);
        else        done_cnt0 <= done_cnt0 + c_CNT_W'(1);
      end
    end
  end

  assign res_valid = (r_state == HOLD);
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
